// File: rtl/ram_wait_state.sv
// ram_wait_state: single-port word RAM with a programmable number of wait
// states per access, per-byte write enables and a registered read port.
//
// Parameters:
//   DATA_WIDTH  - word width in bits (multiple of 8)
//   ADDR_WIDTH  - word address width; depth is 2**ADDR_WIDTH
//   WAIT_STATES - extra cycles between request acceptance and the access (0..15)
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   clr      - synchronous active-low reset (memory contents are preserved)
//   Read     - read request
//   Write    - write request (Read and Write together is an illegal request)
//   address  - word address
//   data_in  - write data
//   byte_en  - per-byte write enable, bit i covers data bits 8i+7:8i
//   data_out - registered read data, changes only on read accesses and reset
//   Done     - one-cycle pulse in the cycle after the access edge
//   Busy     - an access is in progress (state is not IDLE)
//   Error    - one-cycle pulse after an illegal request
module ram_wait_state #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    Read,
  input  logic                    Write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    Done,
  output logic                    Busy,
  output logic                    Error
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  // Counter preload: the access happens on the edge where the counter is 0.
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state_reg;
  logic                    op_write_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [NBYTES-1:0]       be_reg;
  logic [3:0]              cnt_reg;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    req_legal;
  logic                    req_illegal;

  // Access strobe and operands for the current edge
  logic                    acc_en;
  logic                    acc_we;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_data;
  logic [NBYTES-1:0]       acc_be;
  logic [NBYTES-1:0]       lane_we;

  assign accept      = (state_reg == IDLE) || (state_reg == DONE);
  assign req_legal   = Read ^ Write;
  assign req_illegal = Read & Write;

  // With no wait states the access happens on the accepting edge itself, so
  // operands come straight from the ports; otherwise from the captured copy.
  // Gating with clr makes reset discard any access due on the same edge.
  always_comb begin
    acc_en   = 1'b0;
    acc_we   = 1'b0;
    acc_addr = addr_reg;
    acc_data = data_reg;
    acc_be   = be_reg;
    if (clr) begin
      if (WAIT_STATES == 0) begin
        if (accept && req_legal) begin
          acc_en   = 1'b1;
          acc_we   = Write;
          acc_addr = address;
          acc_data = data_in;
          acc_be   = byte_en;
        end
      end else if (state_reg == WAIT && cnt_reg == 4'd0) begin
        acc_en = 1'b1;
        acc_we = op_write_reg;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane_we
      assign lane_we[gi] = acc_en & acc_we & acc_be[gi];
    end
  endgenerate

  // Memory array: no reset so it maps onto block RAM and survives clr.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (lane_we[i]) begin
        mem[acc_addr][8*i +: 8] <= acc_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg    <= IDLE;
      data_out     <= '0;
      Done         <= 1'b0;
      Busy         <= 1'b0;
      Error        <= 1'b0;
      cnt_reg      <= 4'd0;
      op_write_reg <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      be_reg       <= '0;
    end else begin
      Done  <= acc_en;
      Error <= 1'b0;
      if (acc_en && !acc_we) begin
        data_out <= mem[acc_addr];
      end
      case (state_reg)
        IDLE, DONE: begin
          if (req_illegal) begin
            Error     <= 1'b1;
            state_reg <= IDLE;
            Busy      <= 1'b0;
          end else if (req_legal) begin
            op_write_reg <= Write;
            addr_reg     <= address;
            data_reg     <= data_in;
            be_reg       <= byte_en;
            Busy         <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_reg <= DONE;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_INIT;
            end
          end else begin
            state_reg <= IDLE;
            Busy      <= 1'b0;
          end
        end
        WAIT: begin
          Busy <= 1'b1;
          if (cnt_reg == 4'd0) begin
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wait_state.sv
// Directed testbench for ram_wait_state. Three instances cover
// WAIT_STATES = 0, 3 and 2. Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_ram_wait_state;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0: WAIT_STATES = 0
  logic        clr0, r0, w0;
  logic [8:0]  a0;
  logic [31:0] d0, q0;
  logic [3:0]  be0;
  logic        done0, busy0, err0;

  // Instance 3: WAIT_STATES = 3
  logic        clr3, r3, w3;
  logic [8:0]  a3;
  logic [31:0] d3, q3;
  logic [3:0]  be3;
  logic        done3, busy3, err3;

  // Instance 2: WAIT_STATES = 2
  logic        clr2, r2, w2;
  logic [8:0]  a2;
  logic [31:0] d2, q2;
  logic [3:0]  be2;
  logic        done2, busy2, err2;

  ram_wait_state #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .clr(clr0), .Read(r0), .Write(w0), .address(a0), .data_in(d0),
    .byte_en(be0), .data_out(q0), .Done(done0), .Busy(busy0), .Error(err0));

  ram_wait_state #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(3)) dut3 (
    .clk(clk), .clr(clr3), .Read(r3), .Write(w3), .address(a3), .data_in(d3),
    .byte_en(be3), .data_out(q3), .Done(done3), .Busy(busy3), .Error(err3));

  ram_wait_state #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(2)) dut2 (
    .clk(clk), .clr(clr2), .Read(r2), .Write(w2), .address(a2), .data_in(d2),
    .byte_en(be2), .data_out(q2), .Done(done2), .Busy(busy2), .Error(err2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request into instance 3 and wait (bounded) for Done.
  task automatic req3(input logic rd, input logic wr, input logic [8:0] addr,
                      input logic [31:0] data);
    int n;
    r3 = rd; w3 = wr; a3 = addr; d3 = data; be3 = 4'hF;
    tick();
    r3 = 1'b0; w3 = 1'b0;
    n = 0;
    while (!done3 && n < 10) begin
      tick();
      n++;
    end
    check("dut3_req_done", {31'd0, done3}, 32'd1);
    tick();
  endtask

  initial begin
    clr0 = 0; r0 = 0; w0 = 0; a0 = 0; d0 = 0; be0 = 0;
    clr3 = 0; r3 = 0; w3 = 0; a3 = 0; d3 = 0; be3 = 0;
    clr2 = 0; r2 = 0; w2 = 0; a2 = 0; d2 = 0; be2 = 0;
    tick();
    tick();

    // Reset state
    check("rst_data_out", q0, 32'h0);
    check("rst_done",     {31'd0, done0}, 32'd0);
    check("rst_busy",     {31'd0, busy0}, 32'd0);
    check("rst_error",    {31'd0, err0},  32'd0);
    clr0 = 1; clr3 = 1; clr2 = 1;
    tick();

    // ---- WAIT_STATES = 0: write then back-to-back read of 0x1FF ----
    w0 = 1; a0 = 9'h1FF; d0 = 32'hDEADBEEF; be0 = 4'hF;
    tick();
    check("w0_done",  {31'd0, done0}, 32'd1);
    check("w0_busy",  {31'd0, busy0}, 32'd1);
    check("w0_q_hold", q0, 32'h0);
    w0 = 0; r0 = 1; a0 = 9'h1FF;              // read accepted in DONE
    tick();
    check("r0_done",  {31'd0, done0}, 32'd1);
    check("r0_data",  q0, 32'hDEADBEEF);
    r0 = 0;
    tick();
    check("r0_done_low", {31'd0, done0}, 32'd0);
    check("r0_busy_low", {31'd0, busy0}, 32'd0);
    check("r0_q_hold",   q0, 32'hDEADBEEF);

    // ---- byte lanes ----
    w0 = 1; a0 = 9'h005; d0 = 32'h11223344; be0 = 4'hF;
    tick();
    d0 = 32'hAABBCCDD; be0 = 4'h5;
    tick();
    w0 = 0; r0 = 1; be0 = 4'h0;               // byte_en ignored on read
    tick();
    check("lane_data", q0, 32'h11BB33DD);
    r0 = 0; w0 = 1; d0 = 32'hFFFFFFFF; be0 = 4'h0;
    tick();
    check("be0_done", {31'd0, done0}, 32'd1);
    w0 = 0; r0 = 1;
    tick();
    check("be0_unchanged", q0, 32'h11BB33DD);
    r0 = 0;
    tick();

    // ---- illegal request ----
    r0 = 1; w0 = 1; a0 = 9'h005; d0 = 32'h0; be0 = 4'hF;
    tick();
    check("ill_error", {31'd0, err0},  32'd1);
    check("ill_done",  {31'd0, done0}, 32'd0);
    check("ill_busy",  {31'd0, busy0}, 32'd0);
    r0 = 0; w0 = 0;
    tick();
    check("ill_error_pulse", {31'd0, err0}, 32'd0);
    r0 = 1; a0 = 9'h005;
    tick();
    check("post_ill_done", {31'd0, done0}, 32'd1);
    check("post_ill_data", q0, 32'h11BB33DD);
    r0 = 0;
    tick();

    // ---- WAIT_STATES = 3 ----
    req3(1'b0, 1'b1, 9'h0A0, 32'h12345678);
    req3(1'b0, 1'b1, 9'h0B0, 32'hCAFEF00D);
    r3 = 1; a3 = 9'h0A0;
    tick();                                   // edge k
    r3 = 1; a3 = 9'h0B0;                      // ignored while in WAIT
    check("ws3_k_busy", {31'd0, busy3}, 32'd1);
    check("ws3_k_done", {31'd0, done3}, 32'd0);
    tick();                                   // edge k+1
    check("ws3_k1_busy", {31'd0, busy3}, 32'd1);
    check("ws3_k1_done", {31'd0, done3}, 32'd0);
    r3 = 0;
    tick();                                   // edge k+2
    check("ws3_k2_busy", {31'd0, busy3}, 32'd1);
    check("ws3_k2_done", {31'd0, done3}, 32'd0);
    tick();                                   // edge k+3: access
    check("ws3_k3_busy", {31'd0, busy3}, 32'd1);
    check("ws3_k3_done", {31'd0, done3}, 32'd1);
    check("ws3_data",    q3, 32'h12345678);
    tick();
    check("ws3_k4_busy", {31'd0, busy3}, 32'd0);
    check("ws3_k4_done", {31'd0, done3}, 32'd0);

    // ---- WAIT_STATES = 2: reset aborts a pending write ----
    w2 = 1; a2 = 9'h010; d2 = 32'h55AA55AA; be2 = 4'hF;
    tick();
    w2 = 0;
    tick();
    tick();
    check("ws2_pre_done", {31'd0, done2}, 32'd1);
    tick();
    w2 = 1; d2 = 32'h12121212;
    tick();                                   // accepted, now in WAIT
    w2 = 0; clr2 = 0;
    tick();                                   // reset edge
    check("ws2_rst_busy", {31'd0, busy2}, 32'd0);
    check("ws2_rst_q",    q2, 32'h0);
    check("ws2_rst_done", {31'd0, done2}, 32'd0);
    clr2 = 1;
    tick();
    tick();
    check("ws2_no_late_done", {31'd0, done2}, 32'd0);
    r2 = 1; a2 = 9'h010;
    tick();
    r2 = 0;
    tick();
    tick();
    check("ws2_read_done", {31'd0, done2}, 32'd1);
    check("ws2_read_data", q2, 32'h55AA55AA);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_wait_state.md
RAM_WAIT_STATE -- requirements
Module: ram_wait_state

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: address width; depth is exactly 2**ADDR_WIDTH words, all addressable.
REQ-003 SHALL have parameter WAIT_STATES, default 1: extra cycles per access, legal range 0..15.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port clr  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port Read  input  1  read request.
REQ-007 SHALL have port Write  input  1  write request.
REQ-008 SHALL have port address  input  ADDR_WIDTH  word address.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-010 SHALL have port byte_en  input  DATA_WIDTH/8  per-byte write enable; bit i covers data bits 8i+7:8i.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port Busy  output  1  access in progress; requests ignored.
REQ-014 SHALL have port Error  output  1  one-cycle pulse for an illegal request.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and DONE; Busy = (state != IDLE).
REQ-016 SHALL accept a request at a rising edge only in IDLE or DONE; requests in WAIT are ignored.
REQ-017 SHALL treat Read=1 with Write=0 as a read and Write=1 with Read=0 as a write.
REQ-018 SHALL capture address, data_in, byte_en and operation at the accepting edge; later input changes do not affect the access.
REQ-019 SHALL, on acceptance at edge k with WAIT_STATES=0, perform the access at edge k and enter DONE.
REQ-020 SHALL, on acceptance at edge k with WAIT_STATES>0, enter WAIT, count WAIT_STATES edges, perform the access at edge k+WAIT_STATES and enter DONE.
REQ-021 SHALL assert Done exactly in the cycle following the access edge, for one cycle per access.
REQ-022 SHALL, on a write access edge, update only the byte lanes whose byte_en bit is 1; byte_en=0 completes with Done but changes nothing.
REQ-023 SHALL, on a read access edge, load data_out with the full stored word, ignoring byte_en.
REQ-024 SHALL hold data_out unchanged except at read access edges and reset.
REQ-025 SHALL return write data to any later read of the same address, including a read accepted in the DONE cycle of that write.
REQ-026 SHALL leave state DONE for IDLE when no new request is accepted; with WAIT_STATES=0 and continuous requests, stay in DONE with Done high every cycle.
REQ-027 SHALL treat Read=1 with Write=1 at an accepting edge as illegal: no memory access, no Done, Error high for the next cycle, next state IDLE.
REQ-028 SHALL treat Read=0 with Write=0 at an accepting edge as no request.

Reset
REQ-029 SHALL, when clr=0 at a rising edge, force state IDLE, data_out=0, Done=0, Busy=0 and Error=0, overriding any request at that edge.
REQ-030 SHALL abort an access in WAIT on reset; its pending write is discarded, leaving memory unchanged.
REQ-031 SHALL never initialise or clear memory contents on reset.

Verification
REQ-032 SHALL verify, with WAIT_STATES=0: write 0xDEADBEEF to 0x1FF, byte_en=0xF, then read 0x1FF -> Done one cycle after each request edge; data_out=0xDEADBEEF.
REQ-033 SHALL verify, with WAIT_STATES=3: read accepted at edge k -> Busy high from k to k+3; Done high only after edge k+3; address changes during WAIT have no effect.
REQ-034 SHALL verify byte lanes: write 0x11223344 with byte_en=0xF, then 0xAABBCCDD with byte_en=0x5, then read -> data_out=0x11BB33DD.
REQ-035 SHALL verify Read=Write=1 in IDLE -> Error pulse one cycle; Done=0; memory unchanged; the following legal read completes normally.
REQ-036 SHALL verify, with WAIT_STATES=2: clr=0 one edge after a write to 0x010 is accepted -> Busy=0, data_out=0; a later read of 0x010 returns the pre-write value.
